seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
Parametrised, run-time programmable serial bit-sequence detector. It replaces fixed-pattern hard-coded detector FSMs. Pattern, length, don't-care mask and overlap mode are loaded through a config port, and matches are counted. It sits on a serial bit stream with a valid qualifier and drives a registered match pulse plus a saturating match counter.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
CNT_W, 16, width of the saturating match counter
LEN_W, $clog2(PAT_W+1), width of length fields (derived, not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
en  input  1  detector enable; 0 = disabled, history cleared
in_valid  input  1  x is a valid sample this cycle
x  input  1  serial data bit
cfg_wr  input  1  load configuration this cycle
cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first (oldest) bit, bit 0 the newest
cfg_mask  input  PAT_W  1 = compare bit, 0 = don't-care
cfg_len  input  LEN_W  pattern length, legal range 1..PAT_W
cfg_overlap  input  1  1 = overlapping matches allowed
cnt_clr  input  1  clear match counter
match  output  1  one-cycle registered pulse on detection
match_cnt  output  CNT_W  saturating count of matches
armed  output  1  high when history holds >= len valid bits
cfg_err  output  1  one-cycle pulse when cfg_wr is rejected

Behaviour:
- Reset (reset=0 at posedge): pattern=0, mask=0, len=1, overlap=1, history=0, fill=0, state=DISABLED. Outputs: match=0, match_cnt=0, armed=0, cfg_err=0.
- State machine states: DISABLED, FILL, ARMED.
  - DISABLED -> FILL when en=1.
  - FILL -> ARMED when fill reaches len.
  - ARMED -> FILL on a non-overlap match, or on cfg_wr.
  - Any state -> DISABLED when en=0. This clears history and fill; match_cnt is held.
- Sample acceptance: a sample is accepted only when en=1 and in_valid=1. On acceptance, history <= {history[PAT_W-2:0], x} and fill <= min(fill+1, len). With in_valid=0, history and fill are held.
- Match condition, evaluated on an accepted sample using the post-shift history: fill_next >= len and ((history_next ^ pattern) & mask & lenmask) == 0. lenmask has bits [len-1:0] set.
- Latency: match is asserted in the cycle after the accepting edge and lasts 1 cycle per match. Back-to-back matches on consecutive valid samples give a continuously high match.
- Overlap=1: history and fill are untouched on a match.
- Overlap=0: a match forces fill <= 0. History bits are retained but ignored until len new samples arrive.
- match_cnt: +1 per match, saturates at all-ones, never wraps.
  - cnt_clr=1 sets it to 0.
  - cnt_clr and a match in the same cycle: clear wins, result 0.
- Config write:
  - cfg_wr with 1<=cfg_len<=PAT_W: registers load; history and fill clear; state becomes FILL (or DISABLED if en=0). A sample presented in the same cycle is discarded, and no match is produced on that edge.
  - cfg_len=0 or cfg_len>PAT_W: write rejected, configuration and history unchanged, cfg_err pulses 1 cycle.
- Reset asserted mid-stream: all state returns to reset values at that edge, and any pending match is dropped.
- armed mirrors state==ARMED, registered.

Decomposition:
- Package seq_detect_pkg holds:
  - the state encoding (DISABLED=2'd0, FILL=2'd1, ARMED=2'd2)
  - a localparam function computing lenmask from len
  - the LEN_W derivation
- One sub-module, sat_counter (parameter W; inputs inc and clr; output count), is used for match_cnt.
- The FSM, shift history and compare stay in the top module.

Test Plan:
1. PAT_W=8, len=3, pat=3'b101, mask=3'b111, overlap=1; stream 1,0,1,0,1 -> match high the cycle after samples 3 and 5; match_cnt=2.
2. Same config with overlap=0; stream 1,0,1,0,1,0,1 -> matches only after samples 3 and 7; match_cnt=2; armed drops after sample 3.
3. len=4, pat=4'b1001, mask=4'b1001; streams 1,1,0,1 and 1,0,1,1 -> match after sample 4 in both; stream 0,1,1,1 -> no match.
4. len=3, mask=0 (all don't-care), overlap=1 -> no match for samples 1-2, then match every valid sample; inserting in_valid=0 gaps freezes history and creates no matches.
5. CNT_W=2 with 5 matches -> match_cnt sticks at 3. cnt_clr coincident with a match -> 0. cfg_wr with cfg_len=0 -> cfg_err pulse, previous pattern still detected.
6. Mid-stream cfg_wr (sample 2 of 3), en deassertion, and reset=0 each -> fill cleared, no match until len fresh samples; reset returns match_cnt to 0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
// Patterns up to MAX_PAT_W bits are supported by the length-mask helper.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    FILL     = 2'd1,
    ARMED    = 2'd2
  } state_t;

  localparam int MAX_PAT_W = 64;

  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Bits [len-1:0] set; the caller compares only its low PAT_W bits.
  function automatic logic [MAX_PAT_W-1:0] lenmask(input int len);
    logic [MAX_PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_PAT_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Stream, configuration and status bundle of the sequence detector.
interface seq_detect_prog_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
);
  import seq_detect_pkg::*;
  localparam int LEN_W = len_width(PAT_W);

  logic             en;
  logic             in_valid;
  logic             x;
  logic             cfg_wr;
  logic [PAT_W-1:0] cfg_pattern;
  logic [PAT_W-1:0] cfg_mask;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;
  logic             cfg_err;

  modport master (
    output en, in_valid, x, cfg_wr, cfg_pattern, cfg_mask, cfg_len, cfg_overlap, cnt_clr,
    input  match, match_cnt, armed, cfg_err
  );

  modport slave (
    input  en, in_valid, x, cfg_wr, cfg_pattern, cfg_mask, cfg_len, cfg_overlap, cnt_clr,
    output match, match_cnt, armed, cfg_err
  );
endinterface

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_prog.sv
// Run-time programmable serial bit-sequence detector with saturating match counter.
//   state    | meaning
//   DISABLED | en low, history and fill cleared
//   FILL     | collecting samples, fewer than len fresh bits held
//   ARMED    | len fresh bits held, every accepted sample is compared
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              reset,
  seq_detect_prog_if.slave bus
);

  localparam int LEN_W = len_width(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] fill;
  logic             overlap;
  logic [PAT_W-2:0] hist;
  logic             match_q;
  logic             armed_q;
  logic             cfg_err_q;
  logic [CNT_W-1:0] cnt;

  logic             cfg_ok;
  logic             cfg_load;
  logic             accept;
  logic             hit;
  logic [PAT_W-1:0] hist_n;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] fill_nx;

  assign cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PAT_W));
  assign cfg_load = bus.cfg_wr && cfg_ok;
  // A legal config write discards any sample presented on the same edge.
  assign accept   = bus.en && bus.in_valid && !cfg_load;
  assign hist_n   = {hist, bus.x};
  assign fill_inc = (fill < len) ? fill + LEN_W'(1) : len;
  assign hit      = accept && (fill_inc >= len) &&
                    ((MAX_PAT_W'((hist_n ^ pattern) & mask) & lenmask(int'(len))) == '0);
  assign fill_nx  = !accept            ? fill :
                    (hit && !overlap)  ? '0   : fill_inc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= DISABLED;
      pattern   <= '0;
      mask      <= '0;
      len       <= LEN_W'(1);
      overlap   <= 1'b1;
      hist      <= '0;
      fill      <= '0;
      match_q   <= 1'b0;
      armed_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      match_q   <= hit;
      cfg_err_q <= bus.cfg_wr && !cfg_ok;
      if (cfg_load) begin
        pattern <= bus.cfg_pattern;
        mask    <= bus.cfg_mask;
        len     <= bus.cfg_len;
        overlap <= bus.cfg_overlap;
        hist    <= '0;
        fill    <= '0;
        state   <= bus.en ? FILL : DISABLED;
        armed_q <= 1'b0;
      end else if (!bus.en) begin
        hist    <= '0;
        fill    <= '0;
        state   <= DISABLED;
        armed_q <= 1'b0;
      end else begin
        if (accept) begin
          hist <= hist_n[PAT_W-2:0];
          fill <= fill_nx;
        end
        armed_q <= (fill_nx == len);
        case (state)
          DISABLED: state <= (fill_nx == len) ? ARMED : FILL;
          FILL:     if (fill_nx == len) state <= ARMED;
          ARMED:    if (fill_nx != len) state <= FILL;
          default:  state <= DISABLED;
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .clr   (bus.cnt_clr),
    .count (cnt)
  );

  assign bus.match     = match_q;
  assign bus.armed     = armed_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.match_cnt = cnt;

endmodule
